// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared widths and types for the memory arbiter (MEM_ARB_ROUND_ROBIN_EN aware)
package constants_pkg;

    localparam int PHY_LEN    = 20;
    localparam int ICLLEN     = 128;
    localparam int DCLLEN     = 128;
    localparam int LINE_OFF_W = $clog2(ICLLEN / 8);

    typedef logic [PHY_LEN-1:0] paddr_t;
    typedef logic [ICLLEN-1:0]  line_t;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_IC,
        SERVE_DC,
        RESP
    } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_picker.sv
// rtl/mem_arb_picker.sv - combinational grant picker; round-robin tie-break under MEM_ARB_ROUND_ROBIN_EN
module mem_arb_picker (
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_ic,
    output logic gnt_ic,
    output logic gnt_dc
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the requester that was not served last wins.
    assign gnt_dc = dc_req & (~ic_req | last_ic);
`else
    logic unused_last_ic;
    assign unused_last_ic = last_ic;
    assign gnt_dc         = dc_req;
`endif

    assign gnt_ic = ic_req & ~gnt_dc;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache line arbiter for the single memory port (MEM_ARB_ROUND_ROBIN_EN selects round-robin)
module mem_arbiter
    import constants_pkg::*;
#(
    parameter int ADDR_W = PHY_LEN,
    parameter int LINE_W = ICLLEN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_valid_o,
    output logic [LINE_W-1:0] ic_rdata_o,
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic              dc_valid_o,
    output logic [LINE_W-1:0] dc_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << LINE_OFF_W) - 1);

    mem_arb_state_t    state_q;
    mem_arb_state_t    state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] buf_q;
    logic              we_q;
    logic              srv_dc_q;
    logic              last_ic;
    logic              gnt_ic;
    logic              gnt_dc;
    logic              serving;
    logic              grant;
    logic [ADDR_W-1:0] sel_addr;

    assign serving  = (state_q == SERVE_IC) || (state_q == SERVE_DC);
    assign grant    = (state_q == IDLE) && (gnt_ic || gnt_dc);
    assign sel_addr = gnt_dc ? dc_addr_i : ic_addr_i;

    mem_arb_picker u_picker (
        .ic_req  (ic_req_i),
        .dc_req  (dc_req_i),
        .last_ic (last_ic),
        .gnt_ic  (gnt_ic),
        .gnt_dc  (gnt_dc)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_ic_q;

    // Reset value "I-cache last served" lets the D-cache take the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_ic_q <= 1'b1;
        end else if (serving && mem_ready_i) begin
            last_ic_q <= ~srv_dc_q;
        end
    end

    assign last_ic = last_ic_q;
`else
    assign last_ic = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_dc) begin
                    state_d = SERVE_DC;
                end else if (gnt_ic) begin
                    state_d = SERVE_IC;
                end
            end
            SERVE_IC, SERVE_DC: begin
                if (mem_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            we_q     <= 1'b0;
            srv_dc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                addr_q   <= sel_addr & ~OFF_MASK;
                we_q     <= gnt_dc & dc_we_i;
                wdata_q  <= gnt_dc ? dc_wdata_i : '0;
                srv_dc_q <= gnt_dc;
            end
            // Write-backs leave the shared buffer holding the last fill.
            if (serving && mem_ready_i && !we_q) begin
                buf_q <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = serving;
    assign mem_we_o    = serving & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign ic_valid_o  = (state_q == RESP) & ~srv_dc_q;
    assign dc_valid_o  = (state_q == RESP) & srv_dc_q;
    assign ic_rdata_o  = buf_q;
    assign dc_rdata_o  = buf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter (honours MEM_ARB_ROUND_ROBIN_EN)
module tb_mem_arbiter;
    import constants_pkg::*;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ic_req_i;
    logic [19:0]   ic_addr_i;
    logic          ic_valid_o;
    logic [127:0]  ic_rdata_o;
    logic          dc_req_i;
    logic          dc_we_i;
    logic [19:0]   dc_addr_i;
    logic [127:0]  dc_wdata_i;
    logic          dc_valid_o;
    logic [127:0]  dc_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [19:0]   mem_addr_o;
    logic [127:0]  mem_wdata_o;
    logic [127:0]  mem_rdata_i;
    logic          mem_ready_i;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ic_req_i    (ic_req_i),
        .ic_addr_i   (ic_addr_i),
        .ic_valid_o  (ic_valid_o),
        .ic_rdata_o  (ic_rdata_o),
        .dc_req_i    (dc_req_i),
        .dc_we_i     (dc_we_i),
        .dc_addr_i   (dc_addr_i),
        .dc_wdata_i  (dc_wdata_i),
        .dc_valid_o  (dc_valid_o),
        .dc_rdata_o  (dc_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    typedef struct {
        logic         is_dc;
        logic [19:0]  addr;
        logic         we;
        logic [127:0] wdata;
    } mem_t;

    typedef struct {
        logic         is_dc;
        logic         we;
        logic [127:0] rdata;
    } rsp_t;

    mem_t         exp_mem[$];
    rsp_t         exp_rsp[$];
    logic [127:0] buf_model   = '0;
    bit           force_stall = 1'b0;
    bit           last_ic_m   = 1'b1;
    int           n_tests     = 0;
    int           n_fail      = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Memory model: checks each request against the predicted grant order.
    initial begin
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                mem_t e;
                int   w;
                bit   ok;
                mem_ready_i = 1'b0;
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_req", 1'b1, 1'b0);
                    e = '{1'b0, mem_addr_o, mem_we_o, mem_wdata_o};
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_addr", mem_addr_o, e.addr);
                    check("mem_we", mem_we_o, e.we);
                    check("mem_wdata", mem_wdata_o, e.wdata);
                end
                w  = force_stall ? 1000 : (($urandom % 6 == 0) ? 50 : $urandom_range(0, 3));
                ok = 1'b1;
                for (int i = 0; i < w; i++) begin
                    mem_rdata_i = rand_line();
                    @(negedge clk);
                    if (!mem_req_o) begin
                        ok = 1'b0;
                        break;
                    end
                    check("stall_addr", mem_addr_o, e.addr);
                    check("stall_we", mem_we_o, e.we);
                    check("stall_wdata", mem_wdata_o, e.wdata);
                    check("stall_no_valid", ic_valid_o | dc_valid_o, 1'b0);
                end
                if (ok) begin
                    mem_rdata_i = rand_line();
                    mem_ready_i = 1'b1;
                    exp_rsp.push_back('{e.is_dc, e.we, mem_rdata_i});
                    @(negedge clk);
                    check("req_drop_after_ready", mem_req_o, 1'b0);
                    check("valid_after_ready", ic_valid_o | dc_valid_o, 1'b1);
                    mem_ready_i = ($urandom % 2 == 0);
                    mem_rdata_i = rand_line();
                end
            end else begin
                mem_ready_i = ($urandom % 3 == 0);
                mem_rdata_i = rand_line();
            end
        end
    end

    // Response monitor: pops one expected response per valid pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (ic_valid_o || dc_valid_o) begin
                check("one_hot_valid", ic_valid_o & dc_valid_o, 1'b0);
                if (exp_rsp.size() == 0) begin
                    check("spurious_valid", 1'b1, 1'b0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    check("valid_dc", dc_valid_o, r.is_dc);
                    check("valid_ic", ic_valid_o, !r.is_dc);
                    if (!r.we) buf_model = r.rdata;
                end
            end
            check("ic_rdata", ic_rdata_o, buf_model);
            check("dc_rdata", dc_rdata_o, buf_model);
        end
    end

    // kind: 0 = I fill, 1 = D request, 2 = both at once
    task automatic run_round(input int kind);
        mem_t ei, ed;
        bit   dc_first, ic_pend, dc_pend;
        logic [19:0]  a_ic, a_dc;
        logic [127:0] wd;
        logic         we;
        a_ic = 20'($urandom);
        a_dc = 20'($urandom);
        wd   = rand_line();
        we   = 1'($urandom);
        ei   = '{1'b0, a_ic & ~20'hF, 1'b0, '0};
        ed   = '{1'b1, a_dc & ~20'hF, we, wd};
        ic_pend = (kind != 1);
        dc_pend = (kind != 0);
        dc_first = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        dc_first = last_ic_m;
`endif
        if (kind == 0) begin
            exp_mem.push_back(ei);
            last_ic_m = 1'b1;
        end else if (kind == 1) begin
            exp_mem.push_back(ed);
            last_ic_m = 1'b0;
        end else if (dc_first) begin
            exp_mem.push_back(ed);
            exp_mem.push_back(ei);
            last_ic_m = 1'b1;
        end else begin
            exp_mem.push_back(ei);
            exp_mem.push_back(ed);
            last_ic_m = 1'b0;
        end
        ic_addr_i  = a_ic;
        dc_addr_i  = a_dc;
        dc_we_i    = we;
        dc_wdata_i = wd;
        ic_req_i   = ic_pend;
        dc_req_i   = dc_pend;
        for (int c = 0; c < 600 && (ic_pend || dc_pend); c++) begin
            @(negedge clk);
            if (c == 0) check("req_latency", mem_req_o, 1'b1);
            if (ic_valid_o && ic_pend) begin
                ic_pend  = 1'b0;
                ic_req_i = 1'b0;
            end
            if (dc_valid_o && dc_pend) begin
                dc_pend  = 1'b0;
                dc_req_i = 1'b0;
            end
        end
        if (ic_pend || dc_pend) begin
            check("round_timeout", 1'b1, 1'b0);
            finish_tb();
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    initial begin
        rst_i      = 1'b1;
        ic_req_i   = 1'b0;
        ic_addr_i  = '0;
        dc_req_i   = 1'b0;
        dc_we_i    = 1'b0;
        dc_addr_i  = '0;
        dc_wdata_i = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, '0);
        check("rst_mem_wdata", mem_wdata_o, '0);
        check("rst_ic_valid", ic_valid_o, 1'b0);
        check("rst_dc_valid", dc_valid_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk);

        repeat (120) run_round($urandom_range(0, 2));

        // Abandon an I-cache fill by resetting while memory stalls.
        force_stall = 1'b1;
        exp_mem.push_back('{1'b0, 20'h01230, 1'b0, 128'h0});
        ic_addr_i = 20'h01237;
        ic_req_i  = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_req", mem_req_o, 1'b1);
        check("pre_rst_addr", mem_addr_o, 20'h01230);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        buf_model = '0;
        ic_req_i  = 1'b0;
        check("midrst_mem_req", mem_req_o, 1'b0);
        check("midrst_mem_we", mem_we_o, 1'b0);
        check("midrst_mem_addr", mem_addr_o, '0);
        check("midrst_mem_wdata", mem_wdata_o, '0);
        check("midrst_ic_valid", ic_valid_o, 1'b0);
        check("midrst_dc_valid", dc_valid_o, 1'b0);
        @(negedge clk);
        rst_i       = 1'b0;
        force_stall = 1'b0;
        last_ic_m   = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", mem_req_o, 1'b0);

        repeat (30) run_round($urandom_range(0, 2));
        check("queues_drained", 128'(exp_mem.size() + exp_rsp.size()), '0);
        finish_tb();
    end

    initial begin
        #2000000;
        check("global_timeout", 1'b1, 1'b0);
        finish_tb();
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction-cache refill path and the data-cache refill/write-back path. Sits between both cache controllers and the memory interface. Each transaction moves one full 128-bit cache line at a line-aligned physical address. The block holds a registered state machine and a shared line buffer, and returns one-cycle completion pulses to the winning cache.

## Interface
Parameters (defaults come from `constants_pkg`):
- `ADDR_W`, default `PHY_LEN` (20): physical address width.
- `LINE_W`, default `ICLLEN` (128): line width in bits. Must equal `DCLLEN`.

Ports:
- `clk_i`, input, 1: single clock; all logic is rising-edge.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `ic_req_i`, input, 1: I-cache line-fill request.
- `ic_addr_i`, input, `ADDR_W`: I-cache fill address.
- `ic_valid_o`, output, 1: one-cycle pulse; fill data is on `ic_rdata_o`.
- `ic_rdata_o`, output, `LINE_W`: fill line, driven from the shared buffer.
- `dc_req_i`, input, 1: D-cache request.
- `dc_we_i`, input, 1: 1 = write-back, 0 = fill.
- `dc_addr_i`, input, `ADDR_W`: D-cache address.
- `dc_wdata_i`, input, `LINE_W`: write-back line.
- `dc_valid_o`, output, 1: one-cycle completion pulse.
- `dc_rdata_o`, output, `LINE_W`: fill line, driven from the shared buffer.
- `mem_req_o`, output, 1: memory request.
- `mem_we_o`, output, 1: memory write enable.
- `mem_addr_o`, output, `ADDR_W`: memory address. Bits [3:0] are always 0.
- `mem_wdata_o`, output, `LINE_W`: memory write line.
- `mem_rdata_i`, input, `LINE_W`: memory read line.
- `mem_ready_i`, input, 1: memory completion. Read data is valid in the same cycle.

## Operation
- FSM states:
  - `IDLE`: sample requests and pick a winner.
  - `SERVE_IC` / `SERVE_DC`: hold `mem_req_o` until `mem_ready_i`.
  - `RESP`: pulse the winner's valid, then return to `IDLE`.
- Requester contract: hold `*_req_i` high with stable address/data until its `*_valid_o` pulse. Drop `*_req_i` the cycle after the pulse or later.
- Requests are ignored in `RESP`. A request still high in the next `IDLE` cycle is treated as a new transaction.
- In `IDLE` with any request:
  - Latch the winner's address with bits [3:0] forced to 0.
  - Latch `we` (0 for I-cache) and wdata (0 for I-cache).
  - Move to the matching `SERVE_*` state.
- In `SERVE_*`:
  - `mem_req_o` is 1. `mem_addr_o`, `mem_we_o` and `mem_wdata_o` stay stable from the latched values.
  - On a cycle with `mem_ready_i` = 1: capture `mem_rdata_i` into the line buffer (reads only) and go to `RESP`.
- In `RESP`: `mem_req_o` = 0, and the winner's `*_valid_o` = 1 for exactly one cycle.
- On a D-cache write, the line buffer keeps its previous contents. `dc_rdata_o` is don't-care when `dc_we_i` was 1.
- Arbitration when both requests are high in `IDLE`: the D-cache wins (default build).
- Only one transaction is ever outstanding. The losing requester waits, and it cannot be starved by more than one transaction per grant in round-robin mode.

## Timing
- Reset values:
  - State = `IDLE`.
  - `mem_req_o`, `mem_we_o`, `ic_valid_o`, `dc_valid_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, line buffer = 0.
  - Round-robin pointer = "I-cache last served".
- Request in `IDLE` at cycle N:
  - `mem_req_o` = 1 from cycle N+1.
  - If `mem_ready_i` is high in cycle N+1, `*_valid_o` is high in N+2.
  - Best-case turnaround is 3 cycles from request to the next `IDLE`.
- `mem_ready_i` asserted while not in `SERVE_*` is ignored.
- Memory wait states are unbounded. There is no timeout.
- Reset asserted mid-transaction: the next edge forces all reset values, and no valid pulse is emitted. The memory must tolerate the abandoned request.
- `*_req_i` falling during `SERVE_*` (contract violation): the transaction completes anyway and the pulse is still issued.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- Defined: a 1-bit last-served pointer is updated on every entry to `RESP`. On a tie in `IDLE`, the requester not served last wins. After reset the D-cache wins the first tie.
- Undefined: fixed D-cache priority. The pointer is not instantiated.

## Structure
- Add to `constants_pkg`:
  - `typedef logic [PHY_LEN-1:0] paddr_t;`
  - `typedef logic [ICLLEN-1:0] line_t;`
  - `typedef enum logic [1:0] {IDLE, SERVE_IC, SERVE_DC, RESP} mem_arb_state_t;`
  - `LINE_OFF_W = $clog2(ICLLEN/8)` (= 4).
- One combinational sub-module, `mem_arb_picker`:
  - Inputs: `ic_req`, `dc_req`, `last_ic`.
  - Outputs: `gnt_ic`, `gnt_dc`.
  - The round-robin logic lives here under the macro.

## Test plan
- I-cache fill alone: `ic_addr` = 0x01237, memory returns line 0xA5…A5 after 2 wait cycles. Expect `mem_addr_o` = 0x01230, then `ic_valid_o` one cycle with `ic_rdata_o` = 0xA5…A5, and `dc_valid_o` never asserted.
- D-cache write-back: `dc_we` = 1, addr 0x00FF0, wdata 0x0123…CDEF, ready in the first cycle. Expect `mem_we_o` = 1 with stable wdata, then `dc_valid_o` pulses at cycle N+2.
- Simultaneous I and D requests, default build: D is served first, I starts in the `IDLE` after `RESP`. With `MEM_ARB_ROUND_ROBIN_EN` and three back-to-back ties, the grant order is D, I, D.
- Long stall: hold `mem_ready_i` = 0 for 50 cycles. Expect `mem_req_o`, address and data stable throughout, and no valid pulse.
- Reset mid-transaction: assert `rst_i` in `SERVE_IC`. The next cycle shows all outputs 0 and state `IDLE`, with no `ic_valid_o` pulse.
- Stray `mem_ready_i` in `IDLE`/`RESP`: the line buffer is unchanged and no pulse occurs.
